// File: rtl/tcb_lib_arbiter_pkg.sv
// Shared types for the TCB arbiter: arbitration mode, request payload and
// the index-width helper used by the arbiter and its grant search.
package tcb_lib_arbiter_pkg;

    localparam int unsigned TCB_AW = 32;
    localparam int unsigned TCB_DW = 32;

    typedef enum logic {
        TCB_ARB_RR,
        TCB_ARB_FIX
    } tcb_arb_t;

    typedef struct packed {
        logic              wen;
        logic [TCB_AW-1:0] adr;
        logic [TCB_DW-1:0] wdt;
    } tcb_req_t;

    // An index is always at least one bit wide, even for a single manager.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tcb_lib_arbiter_if.sv
// TCB handshake bundle: request with vld/rdy, response data plus the
// response-valid strobe raised by whoever routes the delayed response.
interface tcb_lib_arbiter_if;
    import tcb_lib_arbiter_pkg::*;

    logic              vld;
    logic              rdy;
    tcb_req_t          req;
    logic [TCB_DW-1:0] rsp;
    logic              rvl;

    modport man (output vld, req, input rdy, rsp, rvl);
    modport sub (input vld, req, output rdy, rsp, rvl);

endinterface

// File: rtl/tcb_lib_arbiter_grant.sv
// Combinational grant search: fixed priority from index 0, or round-robin
// starting at ptr_i and wrapping modulo IFN.
module tcb_lib_arbiter_grant
    import tcb_lib_arbiter_pkg::*;
#(
    parameter int unsigned IFN = 2,
    parameter int unsigned IW  = 1
) (
    input  logic [IFN-1:0] req_i,
    input  logic [IW-1:0]  ptr_i,
    input  tcb_arb_t       mode_i,
    output logic [IFN-1:0] gnt_o,
    output logic [IW-1:0]  idx_o
);

    int unsigned base;
    int unsigned pos;
    logic        found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = '0;
        base  = (mode_i == TCB_ARB_FIX) ? 32'd0 : 32'(ptr_i);
        for (int unsigned k = 0; k < IFN; k++) begin
            pos = base + k;
            if (pos >= IFN) begin
                pos = pos - IFN;
            end
            if (!found && req_i[IW'(pos)]) begin
                found            = 1'b1;
                gnt_o[IW'(pos)]  = 1'b1;
                idx_o            = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/tcb_lib_arbiter.sv
// Shares one TCB subordinate among IFN managers; the grant is frozen while
// the subordinate stalls and responses are routed back after DLY cycles.
module tcb_lib_arbiter
    import tcb_lib_arbiter_pkg::*;
#(
    parameter int unsigned IFN = 2,
    parameter tcb_arb_t    ARB = TCB_ARB_RR,
    parameter int unsigned DLY = 1
) (
    input  logic           clk,
    input  logic           rst,
    tcb_lib_arbiter_if.sub man [IFN],
    tcb_lib_arbiter_if.man sub
);

    localparam int unsigned IW = idx_width(IFN);

    logic [IFN-1:0] req_vld;
    tcb_req_t       req_pld [IFN];
    logic [IFN-1:0] arb_gnt;
    logic [IFN-1:0] gnt;
    logic [IW-1:0]  arb_idx;
    logic [IW-1:0]  idx;
    logic           any;
    logic           trn;

    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  hold_q, hold_d;
    logic           lock_q, lock_d;

    logic           rsp_vld;
    logic [IW-1:0]  rsp_idx;

    tcb_lib_arbiter_grant #(
        .IFN (IFN),
        .IW  (IW)
    ) u_grant (
        .req_i  (req_vld),
        .ptr_i  (ptr_q),
        .mode_i (ARB),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx)
    );

    assign any     = |req_vld;
    assign idx     = lock_q ? hold_q : arb_idx;
    assign trn     = any & sub.rdy;
    assign sub.vld = any;
    assign sub.req = req_pld[idx];

    always_comb begin
        ptr_d  = ptr_q;
        hold_d = hold_q;
        lock_d = lock_q;
        if (trn) begin
            lock_d = 1'b0;
            ptr_d  = (idx == IW'(IFN - 1)) ? '0 : idx + 1'b1;
        end else if (any) begin
            lock_d = 1'b1;
            hold_d = idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q  <= '0;
            hold_q <= '0;
            lock_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            hold_q <= hold_d;
            lock_q <= lock_d;
        end
    end

    if (DLY == 0) begin : g_comb
        assign rsp_vld = trn;
        assign rsp_idx = idx;
    end else begin : g_pipe
        // Each stage holds {issuer index, transfer flag}; stage 1 is the youngest.
        logic [DLY:1][IW:0] pipe_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pipe_q <= '0;
            end else begin
                pipe_q    <= pipe_q << (IW + 1);
                pipe_q[1] <= {idx, trn};
            end
        end

        assign {rsp_idx, rsp_vld} = pipe_q[DLY];
    end

    for (genvar i = 0; i < IFN; i++) begin : g_man
        logic sel;
        assign req_vld[i]  = man[i].vld;
        assign req_pld[i]  = man[i].req;
        assign gnt[i]      = lock_q ? (hold_q == IW'(i)) : arb_gnt[i];
        assign sel         = rsp_vld && (rsp_idx == IW'(i));
        assign man[i].rdy  = sub.rdy & gnt[i];
        assign man[i].rsp  = sel ? sub.rsp : '0;
        assign man[i].rvl  = sel;
    end

endmodule

// File: tb/tb_tcb_lib_arbiter.sv
// Directed bench: three 3-manager arbiters (RR/DLY1, FIX/DLY1, RR/DLY2)
// sharing clock and reset, each with a small subordinate model.
module tb_tcb_lib_arbiter;
    import tcb_lib_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    tcb_lib_arbiter_if m_rr [3] ();
    tcb_lib_arbiter_if m_fx [3] ();
    tcb_lib_arbiter_if m_d2 [3] ();
    tcb_lib_arbiter_if s_rr ();
    tcb_lib_arbiter_if s_fx ();
    tcb_lib_arbiter_if s_d2 ();

    logic [2:0]  rr_vld = '0, fx_vld = '0, d2_vld = '0;
    tcb_req_t    rr_req [3];
    tcb_req_t    fx_req [3];
    tcb_req_t    d2_req [3];
    logic [2:0]  rr_rdy, fx_rdy, d2_rdy;
    logic [2:0]  rr_rvl, fx_rvl, d2_rvl;
    logic [31:0] rr_rdt [3];
    logic [31:0] fx_rdt [3];
    logic [31:0] d2_rdt [3];
    logic        rr_srdy = 1'b1;

    for (genvar i = 0; i < 3; i++) begin : g_conn
        assign m_rr[i].vld = rr_vld[i];
        assign m_rr[i].req = rr_req[i];
        assign rr_rdy[i]   = m_rr[i].rdy;
        assign rr_rvl[i]   = m_rr[i].rvl;
        assign rr_rdt[i]   = m_rr[i].rsp;
        assign m_fx[i].vld = fx_vld[i];
        assign m_fx[i].req = fx_req[i];
        assign fx_rdy[i]   = m_fx[i].rdy;
        assign fx_rvl[i]   = m_fx[i].rvl;
        assign fx_rdt[i]   = m_fx[i].rsp;
        assign m_d2[i].vld = d2_vld[i];
        assign m_d2[i].req = d2_req[i];
        assign d2_rdy[i]   = m_d2[i].rdy;
        assign d2_rvl[i]   = m_d2[i].rvl;
        assign d2_rdt[i]   = m_d2[i].rsp;
    end

    tcb_lib_arbiter #(.IFN(3), .ARB(TCB_ARB_RR), .DLY(1)) dut_rr (
        .clk(clk), .rst(rst), .man(m_rr), .sub(s_rr));
    tcb_lib_arbiter #(.IFN(3), .ARB(TCB_ARB_FIX), .DLY(1)) dut_fx (
        .clk(clk), .rst(rst), .man(m_fx), .sub(s_fx));
    tcb_lib_arbiter #(.IFN(3), .ARB(TCB_ARB_RR), .DLY(2)) dut_d2 (
        .clk(clk), .rst(rst), .man(m_d2), .sub(s_d2));

    // Word memory behind the RR arbiter; words preset to 0x1000+index on reset.
    logic [31:0] mem [16];
    logic [31:0] rr_rd;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) mem[4'(i)] <= 32'h1000 + 32'(i);
            rr_rd <= '0;
        end else if (s_rr.vld && s_rr.rdy) begin
            if (s_rr.req.wen) mem[s_rr.req.adr[5:2]] <= s_rr.req.wdt;
            else              rr_rd <= mem[s_rr.req.adr[5:2]];
        end
    end
    assign s_rr.rdy = rr_srdy;
    assign s_rr.rsp = rr_rd;
    assign s_rr.rvl = 1'b0;

    // Echo subordinates: response = tag + request address after 1 or 2 cycles.
    logic [31:0] fx_e, d2_e1, d2_e2;
    always @(posedge clk) begin
        if (s_fx.vld && s_fx.rdy) fx_e <= {16'hF000, s_fx.req.adr[15:0]};
        if (s_d2.vld && s_d2.rdy) d2_e1 <= {16'hE000, s_d2.req.adr[15:0]};
        d2_e2 <= d2_e1;
    end
    assign s_fx.rdy = 1'b1;
    assign s_fx.rsp = fx_e;
    assign s_fx.rvl = 1'b0;
    assign s_d2.rdy = 1'b1;
    assign s_d2.rsp = d2_e2;
    assign s_d2.rvl = 1'b0;

    task automatic chk_v(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rr_req[i] = '{wen: 1'b0, adr: 32'h0, wdt: 32'h0};
            fx_req[i] = '{wen: 1'b0, adr: 32'h0, wdt: 32'h0};
            d2_req[i] = '{wen: 1'b0, adr: 32'h0, wdt: 32'h0};
        end
        #2;
        chk_v("reset_rr_rvl", rr_rvl, 3'b000);
        chk_v("reset_fx_rvl", fx_rvl, 3'b000);
        chk_v("reset_d2_rvl", d2_rvl, 3'b000);
        step();
        step();
        rst = 1'b1;
        step();

        // Round robin with all three requesting: 0,1,2,0,1,2.
        rr_req[0] = '{wen: 1'b0, adr: 32'h00, wdt: 32'h0};
        rr_req[1] = '{wen: 1'b0, adr: 32'h04, wdt: 32'h0};
        rr_req[2] = '{wen: 1'b0, adr: 32'h08, wdt: 32'h0};
        rr_vld = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk_v("rr_grant", rr_rdy, 3'(1 << (k % 3)));
            if (k > 0) begin
                chk_v("rr_rvl", rr_rvl, 3'(1 << ((k - 1) % 3)));
                chk_w("rr_rdt", rr_rdt[0] | rr_rdt[1] | rr_rdt[2], 32'h1000 + 32'((k - 1) % 3));
            end
            step();
        end
        rr_vld = 3'b000;
        #1;
        chk_v("rr_rvl_last", rr_rvl, 3'b100);
        chk_w("rr_rdt_last", rr_rdt[2], 32'h1002);
        step();

        // Lock: man1 stalled for three cycles, man0 joins but must wait.
        rr_req[1] = '{wen: 1'b0, adr: 32'h14, wdt: 32'h0};
        rr_srdy = 1'b0;
        rr_vld  = 3'b010;
        #1;
        chk_w("lock_first", s_rr.req.adr, 32'h14);
        chk_v("lock_rdy_low", rr_rdy, 3'b000);
        step();
        rr_vld = 3'b011;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk_w("lock_hold", s_rr.req.adr, 32'h14);
            step();
        end
        rr_srdy = 1'b1;
        #1;
        chk_v("lock_trn", rr_rdy, 3'b010);
        step();
        rr_vld = 3'b001;
        #1;
        chk_v("lock_next", rr_rdy, 3'b001);
        chk_v("lock_rvl", rr_rvl, 3'b010);
        chk_w("lock_rdt", rr_rdt[1], 32'h1005);
        step();
        rr_vld = 3'b000;
        #1;
        chk_v("lock_rvl0", rr_rvl, 3'b001);
        chk_w("lock_rdt0", rr_rdt[0], 32'h1000);
        step();

        // Write by man0 then read of the same word by man1.
        rr_req[0] = '{wen: 1'b1, adr: 32'h10, wdt: 32'hDEADBEEF};
        rr_req[1] = '{wen: 1'b0, adr: 32'h10, wdt: 32'h0};
        rr_vld = 3'b001;
        #1;
        chk_v("wr_grant", rr_rdy, 3'b001);
        step();
        rr_vld = 3'b010;
        #1;
        chk_v("rd_grant", rr_rdy, 3'b010);
        chk_v("wr_rvl", rr_rvl, 3'b001);
        chk_w("rd_rdt_early", rr_rdt[1], 32'h0);
        step();
        rr_vld = 3'b000;
        #1;
        chk_v("rd_rvl", rr_rvl, 3'b010);
        chk_w("rd_rdt", rr_rdt[1], 32'hDEADBEEF);
        chk_w("wr_no_rdt", rr_rdt[0], 32'h0);
        step();

        // Fixed priority: man0 starves man2 while it keeps requesting.
        fx_req[0] = '{wen: 1'b0, adr: 32'h30, wdt: 32'h0};
        fx_req[2] = '{wen: 1'b0, adr: 32'h38, wdt: 32'h0};
        fx_vld = 3'b101;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk_v("fix_grant", fx_rdy, 3'b001);
            if (k > 0) begin
                chk_v("fix_rvl", fx_rvl, 3'b001);
                chk_w("fix_rdt", fx_rdt[0], 32'hF0000030);
            end
            step();
        end
        fx_vld = 3'b100;
        #1;
        chk_v("fix_man2", fx_rdy, 3'b100);
        step();
        fx_vld = 3'b000;
        #1;
        chk_v("fix_rvl2", fx_rvl, 3'b100);
        chk_w("fix_rdt2", fx_rdt[2], 32'hF0000038);
        step();

        // DLY=2: back-to-back transfers 2,0,1 return in order with no gaps.
        d2_req[0] = '{wen: 1'b0, adr: 32'h20, wdt: 32'h0};
        d2_req[1] = '{wen: 1'b0, adr: 32'h24, wdt: 32'h0};
        d2_req[2] = '{wen: 1'b0, adr: 32'h28, wdt: 32'h0};
        d2_vld = 3'b100;
        #1;
        chk_v("d2_g2", d2_rdy, 3'b100);
        step();
        d2_vld = 3'b001;
        #1;
        chk_v("d2_g0", d2_rdy, 3'b001);
        chk_v("d2_rvl_none", d2_rvl, 3'b000);
        step();
        d2_vld = 3'b010;
        #1;
        chk_v("d2_g1", d2_rdy, 3'b010);
        chk_v("d2_rvl2", d2_rvl, 3'b100);
        chk_w("d2_rdt2", d2_rdt[2], 32'hE0000028);
        step();
        d2_vld = 3'b000;
        #1;
        chk_v("d2_rvl0", d2_rvl, 3'b001);
        chk_w("d2_rdt0", d2_rdt[0], 32'hE0000020);
        step();
        #1;
        chk_v("d2_rvl1", d2_rvl, 3'b010);
        chk_w("d2_rdt1", d2_rdt[1], 32'hE0000024);
        step();
        #1;
        chk_v("d2_rvl_end", d2_rvl, 3'b000);
        step();

        // Reset with a response in flight; pointer restarts at 0 afterwards.
        rr_req[0] = '{wen: 1'b0, adr: 32'h0C, wdt: 32'h0};
        rr_vld = 3'b001;
        #1;
        chk_v("rst_pre_grant", rr_rdy, 3'b001);
        step();
        rr_vld = 3'b000;
        rst    = 1'b0;
        #1;
        chk_v("rst_flush", rr_rvl, 3'b000);
        step();
        chk_v("rst_hold", rr_rvl, 3'b000);
        rst = 1'b1;
        rr_req[0] = '{wen: 1'b0, adr: 32'h00, wdt: 32'h0};
        rr_vld = 3'b111;
        #1;
        chk_v("rst_first_grant", rr_rdy, 3'b001);
        step();
        rr_vld = 3'b000;
        #1;
        chk_v("rst_after_rvl", rr_rvl, 3'b001);
        chk_w("rst_after_rdt", rr_rdt[0], 32'h1000);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
